// File: rtl/mshr_pkg.sv
// Shared definitions for the MSHR refill engine.
// Provides the width helper, derived-width functions and the refill FSM state encoding.
package mshr_pkg;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

   function automatic int byte_off(input int data_width);
      return clog2(data_width / 8);
   endfunction

   function automatic int word_offset(input int words_per_line);
      return clog2(words_per_line);
   endfunction

   function automatic int way_bits(input int num_ways);
      return clog2(num_ways);
   endfunction

   function automatic int line_width(input int data_width, input int words_per_line);
      return data_width * words_per_line;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/mshr_line_buf.sv
// Word-addressed refill line register: one word written per accepted beat, with the
// pending write-miss word substituted for the memory beat when merge_en is set.
module mshr_line_buf
   import mshr_pkg::*;
#(
   parameter  int DATA_WIDTH     = 32,
   parameter  int WORDS_PER_LINE = 4,
   localparam int WORD_OFFSET    = word_offset(WORDS_PER_LINE),
   localparam int LINE_WIDTH     = line_width(DATA_WIDTH, WORDS_PER_LINE)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   we,
   input  logic [WORD_OFFSET-1:0] idx,
   input  logic [DATA_WIDTH-1:0]  mem_dat,
   input  logic                   merge_en,
   input  logic [DATA_WIDTH-1:0]  merge_dat,
   output logic [DATA_WIDTH-1:0]  wr_dat,
   output logic [LINE_WIDTH-1:0]  line
);

   logic [LINE_WIDTH-1:0] line_q;

   assign wr_dat = merge_en ? merge_dat : mem_dat;
   assign line   = line_q;

   // NOTE: the line buffer is built from flops, not a RAM macro, so it can take the reset;
   // a true memory array would not be reset and would rely on every word being rewritten.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) begin
         line_q <= '0;
      end else if (clr) begin
         line_q <= '0;
      end else if (we) begin
         line_q[idx*DATA_WIDTH +: DATA_WIDTH] <= wr_dat;
      end
   end

endmodule

// File: rtl/mshr_refill_engine.sv
// Single-line MSHR refill engine: fetches one line beat by beat, returns the requested word
// early and merges write-miss data. Define CRITICAL_WORD_FIRST_EN to start at the requested word.
module mshr_refill_engine
   import mshr_pkg::*;
#(
   parameter  int ADR_WIDTH      = 32,
   parameter  int DATA_WIDTH     = 32,
   parameter  int WORDS_PER_LINE = 4,
   parameter  int NUM_WAYS       = 4,
   localparam int BYTE_OFF       = byte_off(DATA_WIDTH),
   localparam int WORD_OFFSET    = word_offset(WORDS_PER_LINE),
   localparam int WAY_BITS       = way_bits(NUM_WAYS),
   localparam int LINE_WIDTH     = line_width(DATA_WIDTH, WORDS_PER_LINE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_cc2mshr,
   input  logic [ADR_WIDTH-1:0]  adr_cc2mshr,
   input  logic [WAY_BITS-1:0]   way_cc2mshr,
   input  logic                  wr_cc2mshr,
   input  logic [DATA_WIDTH-1:0] dat_cpu2mshr,
   output logic                  busy_mshr2cc,
   output logic                  req_mshr2mem,
   output logic [ADR_WIDTH-1:0]  adr_mshr2mem,
   input  logic                  ack_mem2mshr,
   input  logic [DATA_WIDTH-1:0] dat_mem2mshr,
   output logic                  crit_vld_mshr2cpu,
   output logic [DATA_WIDTH-1:0] crit_dat_mshr2cpu,
   output logic                  fill_vld_mshr2cc,
   output logic [LINE_WIDTH-1:0] fill_dat_mshr2cc,
   output logic [ADR_WIDTH-1:0]  fill_adr_mshr2cc,
   output logic [WAY_BITS-1:0]   fill_way_mshr2cc
);

   localparam int LINE_OFF  = WORD_OFFSET + BYTE_OFF;
   localparam int TAG_WIDTH = ADR_WIDTH - LINE_OFF;
   localparam logic [WORD_OFFSET-1:0] LAST_BEAT = WORD_OFFSET'(WORDS_PER_LINE - 1);
   localparam logic [WORD_OFFSET-1:0] ONE       = WORD_OFFSET'(1);

   state_e                 state_q, state_d;
   logic [WORD_OFFSET-1:0] beat_cnt_q, first_idx_q, crit_idx_q;
   logic [TAG_WIDTH-1:0]   line_adr_q;
   logic [WAY_BITS-1:0]    way_q;
   logic                   wr_q;
   logic [DATA_WIDTH-1:0]  wdat_q;
   logic [ADR_WIDTH-1:0]   mem_adr_q;
   logic                   crit_vld_q;
   logic [DATA_WIDTH-1:0]  crit_dat_q;

   logic                   start_acc, beat_acc, crit_hit, merge_en;
   logic [WORD_OFFSET-1:0] start_crit, start_first, beat_idx, next_idx;
   logic [DATA_WIDTH-1:0]  wr_word;
   logic                   unused_byte_bits;

   assign start_crit       = adr_cc2mshr[BYTE_OFF +: WORD_OFFSET];
   assign unused_byte_bits = ^adr_cc2mshr[BYTE_OFF-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
   assign start_first = start_crit;
`else
   assign start_first = '0;
`endif

   // Beat index wraps naturally in WORD_OFFSET bits, giving the wrapped critical-word order.
   assign beat_idx  = first_idx_q + beat_cnt_q;
   assign next_idx  = beat_idx + ONE;
   assign start_acc = (state_q == IDLE) && start_cc2mshr;
   assign beat_acc  = (state_q == FETCH) && ack_mem2mshr;
   assign crit_hit  = beat_acc && (beat_idx == crit_idx_q);
   assign merge_en  = wr_q && (beat_idx == crit_idx_q);

   always_ff @(posedge clk) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d          = state_q;
      busy_mshr2cc     = 1'b1;
      req_mshr2mem     = 1'b0;
      fill_vld_mshr2cc = 1'b0;
      unique case (state_q)
         IDLE: begin
            busy_mshr2cc = 1'b0;
            if (start_cc2mshr) state_d = FETCH;
         end
         FETCH: begin
            req_mshr2mem = 1'b1;
            if (ack_mem2mshr && (beat_cnt_q == LAST_BEAT)) state_d = DONE;
         end
         DONE: begin
            fill_vld_mshr2cc = 1'b1;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         beat_cnt_q  <= '0;
         first_idx_q <= '0;
         crit_idx_q  <= '0;
         line_adr_q  <= '0;
         way_q       <= '0;
         wr_q        <= 1'b0;
         wdat_q      <= '0;
         mem_adr_q   <= '0;
         crit_vld_q  <= 1'b0;
         crit_dat_q  <= '0;
      end else begin
         crit_vld_q <= crit_hit;
         if (start_acc) begin
            line_adr_q  <= adr_cc2mshr[ADR_WIDTH-1:LINE_OFF];
            way_q       <= way_cc2mshr;
            wr_q        <= wr_cc2mshr;
            wdat_q      <= dat_cpu2mshr;
            crit_idx_q  <= start_crit;
            first_idx_q <= start_first;
            beat_cnt_q  <= '0;
            mem_adr_q   <= {adr_cc2mshr[ADR_WIDTH-1:LINE_OFF], start_first, {BYTE_OFF{1'b0}}};
         end
         if (beat_acc) begin
            beat_cnt_q <= beat_cnt_q + ONE;
            mem_adr_q  <= {line_adr_q, next_idx, {BYTE_OFF{1'b0}}};
         end
         if (crit_hit) crit_dat_q <= wr_word;
      end
   end

   mshr_line_buf #(
      .DATA_WIDTH     (DATA_WIDTH),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_line_buf (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_acc),
      .we        (beat_acc),
      .idx       (beat_idx),
      .mem_dat   (dat_mem2mshr),
      .merge_en  (merge_en),
      .merge_dat (wdat_q),
      .wr_dat    (wr_word),
      .line      (fill_dat_mshr2cc)
   );

   assign adr_mshr2mem      = mem_adr_q;
   assign crit_vld_mshr2cpu = crit_vld_q;
   assign crit_dat_mshr2cpu = crit_dat_q;
   assign fill_adr_mshr2cc  = {line_adr_q, {LINE_OFF{1'b0}}};
   assign fill_way_mshr2cc  = way_q;

endmodule

// File: doc/mshr_refill_engine.md
Name: mshr_refill_engine

Overview:
Parametrised successor to the single-line MSHR refill path inside the cache controller. On a miss it fetches one cache line from memory, one word per memory ack, and assembles the line in a buffer. It returns the requested word to the CPU early, before the line completes, and merges pending write-miss data into the line. When the line is complete it hands the line, line address and victim way back to the controller for the data-memory write.

Parameters:
ADR_WIDTH, 32, address width in bits
DATA_WIDTH, 32, word width in bits; power of two, at least 8
WORDS_PER_LINE, 4, words per cache line; power of two, at least 2
NUM_WAYS, 4, associativity; used only to size the way field
Derived: BYTE_OFF = clog2(DATA_WIDTH/8), WORD_OFFSET = clog2(WORDS_PER_LINE), WAY_BITS = clog2(NUM_WAYS), LINE_WIDTH = DATA_WIDTH*WORDS_PER_LINE

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
start_cc2mshr  in  1  miss allocate; sampled only in IDLE
adr_cc2mshr  in  ADR_WIDTH  miss byte address
way_cc2mshr  in  WAY_BITS  victim way
wr_cc2mshr  in  1  1 = write miss (merge), 0 = read miss
dat_cpu2mshr  in  DATA_WIDTH  write-miss data
busy_mshr2cc  out  1  high when state is not IDLE
req_mshr2mem  out  1  memory request, held until the last beat is acked
adr_mshr2mem  out  ADR_WIDTH  word-aligned address of the current beat
ack_mem2mshr  in  1  one beat accepted per cycle ack is high
dat_mem2mshr  in  DATA_WIDTH  beat data, valid with ack
crit_vld_mshr2cpu  out  1  one-cycle pulse: requested word available
crit_dat_mshr2cpu  out  DATA_WIDTH  requested word, merged write data if wr
fill_vld_mshr2cc  out  1  one-cycle pulse: line complete
fill_dat_mshr2cc  out  LINE_WIDTH  assembled line; word i at bits [i*DATA_WIDTH +: DATA_WIDTH]
fill_adr_mshr2cc  out  ADR_WIDTH  line-aligned address (low WORD_OFFSET+BYTE_OFF bits zero)
fill_way_mshr2cc  out  WAY_BITS  latched victim way

Behaviour:
- Reset: when rst is 0 at a clock edge, state goes to IDLE; every output, the beat counter and the line buffer clear to 0. Reset mid-refill aborts the refill with no crit_vld and no fill_vld.
- States:
  - IDLE: on start, latch address, way, wr and write data; set crit_idx = adr[BYTE_OFF +: WORD_OFFSET]; set beat_cnt = 0; go to FETCH.
  - FETCH: req high. Each cycle with ack high stores one beat and increments beat_cnt. On the ack of beat WORDS_PER_LINE-1, go to DONE.
  - DONE: fill_vld is high for exactly this cycle; return to IDLE next cycle.
- Beat index = (first_idx + beat_cnt) mod WORDS_PER_LINE; natural wrap of the WORD_OFFSET-bit add.
- adr_mshr2mem = {line address bits, beat index, BYTE_OFF zeros}. It is registered and updates the cycle after each ack.
- Back-to-back acks are legal; the minimum refill is WORDS_PER_LINE cycles in FETCH.
- Timing:
  - req rises the cycle after start is sampled.
  - crit_vld pulses the cycle after the ack of the beat whose index equals crit_idx.
  - fill_vld pulses the cycle after the final ack.
- Write merge: when wr is set, the line word at crit_idx takes dat_cpu2mshr and the memory beat for that word is discarded; crit_dat returns the merged data.
- Ignored inputs:
  - start outside IDLE is ignored; the controller must check busy.
  - ack in IDLE or DONE is ignored.
- Ack arriving in the same cycle as the transition into FETCH is impossible, because req is still low in that cycle; any ack then is ignored.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: first_idx = crit_idx, so the wrapped fetch starts at the requested word and crit_vld follows the first ack.
- Undefined: first_idx = 0, giving a sequential fetch; crit_vld follows the ack of beat crit_idx.
- Fill contents are identical in both modes.

Decomposition:
- Package mshr_pkg: clog2 function, derived widths (BYTE_OFF, WORD_OFFSET, WAY_BITS, LINE_WIDTH), state encoding (IDLE, FETCH, DONE).
- One sub-module: mshr_line_buf, the word-addressed line register with write-enable, merge mux and clear.

Test Plan:
- Read miss, CRITICAL_WORD_FIRST_EN defined, adr 0xFF07BD08 (crit_idx 2), beats 0x11111111, 0x22222222, 0x33333333, 0x44444444:
  - adr_mshr2mem sequence 0xFF07BD08, 0xFF07BD0C, 0xFF07BD00, 0xFF07BD04.
  - crit_dat = 0x11111111 one cycle after the first ack.
  - fill_dat = 0x22222222_11111111_44444444_33333333; fill_adr = 0xFF07BD00.
- Same stimulus, macro undefined:
  - adr sequence 0xFF07BD00, 0xFF07BD04, 0xFF07BD08, 0xFF07BD0C.
  - crit_vld follows the third ack with crit_dat = 0x33333333.
  - fill_dat = 0x44444444_33333333_22222222_11111111.
- Write miss, adr 0xFFFFFD08, dat_cpu2mshr 0xAA8AAAA4, way 3, all beats 0xFFFFFFFF:
  - fill_dat word 2 = 0xAA8AAAA4, other words 0xFFFFFFFF.
  - fill_way = 3; crit_dat = 0xAA8AAAA4.
- Acks on alternate cycles (ack, gap, ack, ...):
  - req stays high across gaps; adr holds during gaps.
  - fill_vld pulses once; busy falls the cycle after fill_vld.
- Reset low after the second ack: all outputs 0 next cycle; no fill_vld; a new start then refills cleanly.
- start asserted while busy, plus ack while idle: both ignored; the line matches the first request only.
